// File: rtl/sram_port_arbiter_if.sv
// Request/response bundle between the IF/MEM requesters, the arbiter and the SRAM macro.
// slave: arbiter view; master: requester/memory side view.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_gnt;
  logic              inst_resp;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_gnt;
  logic              data_resp;
  logic [31:0]       data_rdata;

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  sram_rdata,
    output inst_gnt, inst_resp, inst_rdata,
    output data_gnt, data_resp, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output sram_rdata,
    input  inst_gnt, inst_resp, inst_rdata,
    input  data_gnt, data_resp, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access, one grant per cycle.
// SRAM_ARB_RR_EN: replaces data priority + starvation guard with 1-bit round-robin.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic valid;
    logic is_data;
    logic is_read;
  } owner_t;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("MAX_WAIT must be within 1..15");
  end

  logic              inst_gnt_c;
  logic              data_gnt_c;
  logic              inst_resp_c;
  logic              data_resp_c;
  owner_t            owner_q, owner_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

`ifdef SRAM_ARB_RR_EN
  logic last_data_q, last_data_d;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    data_gnt_c  = 1'b0;
    inst_gnt_c  = 1'b0;
    last_data_d = last_data_q;
    if (!reset) begin
      data_gnt_c = bus.data_req && !(bus.inst_req && last_data_q);
      inst_gnt_c = bus.inst_req && !data_gnt_c;
    end
    if (data_gnt_c) begin
      last_data_d = 1'b1;
    end else if (inst_gnt_c) begin
      last_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Data has priority until inst has lost WAIT_LIMIT consecutive times.
  always_comb begin
    data_gnt_c   = 1'b0;
    inst_gnt_c   = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (!reset) begin
      data_gnt_c = bus.data_req && !(bus.inst_req && (starve_cnt_q == WAIT_LIMIT));
      inst_gnt_c = bus.inst_req && !data_gnt_c;
    end
    if (!bus.inst_req || inst_gnt_c) begin
      starve_cnt_d = '0;
    end else if (data_gnt_c && (starve_cnt_q != WAIT_LIMIT)) begin
      starve_cnt_d = CNT_W'(starve_cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // SRAM drive in the grant cycle, plus the owner tag that steers next cycle's response.
  always_comb begin
    bus.sram_en    = inst_gnt_c | data_gnt_c;
    bus.sram_we    = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (data_gnt_c) begin
      bus.sram_we    = bus.data_wr ? bus.data_wstrb : STRB_W'(0);
      bus.sram_addr  = {bus.data_addr[ADDR_W-1:2], 2'b00};
      bus.sram_wdata = bus.data_wdata;
    end else if (inst_gnt_c) begin
      bus.sram_addr  = {bus.inst_addr[ADDR_W-1:2], 2'b00};
    end
    owner_d.valid   = inst_gnt_c | data_gnt_c;
    owner_d.is_data = data_gnt_c;
    owner_d.is_read = !(data_gnt_c && bus.data_wr);
  end

  // Read data is passed through during the response cycle, then held.
  always_comb begin
    inst_resp_c  = owner_q.valid && !owner_q.is_data && !reset;
    data_resp_c  = owner_q.valid && owner_q.is_data && !reset;
    inst_rdata_d = inst_resp_c ? bus.sram_rdata : inst_rdata_q;
    data_rdata_d = (data_resp_c && owner_q.is_read) ? bus.sram_rdata : data_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      owner_q      <= owner_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus.inst_gnt   = inst_gnt_c;
  assign bus.data_gnt   = data_gnt_c;
  assign bus.inst_resp  = inst_resp_c;
  assign bus.data_resp  = data_resp_c;
  assign bus.inst_rdata = inst_rdata_d;
  assign bus.data_rdata = data_rdata_d;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, per-cycle reference model, directed scenarios.
// Honours SRAM_ARB_RR_EN for the expected arbitration policy.
module tb_sram_port_arbiter;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic reset;

  sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sram_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: environment SRAM (driven by the DUT) and the reference model's copy.
  logic [31:0] sram_mem [logic [29:0]];
  logic [31:0] ref_mem  [logic [29:0]];

  function automatic logic [31:0] dflt(input logic [29:0] idx);
    return 32'(idx) ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [29:0] idx);
    return sram_mem.exists(idx) ? sram_mem[idx] : dflt(idx);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : dflt(idx);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Write-first single-port SRAM; request captured mid-cycle, executed at the edge.
  logic        s_en;
  logic [3:0]  s_we;
  logic [31:0] s_addr, s_wdata;

  always @(negedge clk) begin
    s_en    = bus.sram_en;
    s_we    = bus.sram_we;
    s_addr  = bus.sram_addr;
    s_wdata = bus.sram_wdata;
  end

  always @(posedge clk) begin : sram_env
    logic [31:0] w;
    if (s_en === 1'b1) begin
      w = merge(sram_rd(s_addr[31:2]), s_wdata, s_we);
      if (|s_we) sram_mem[s_addr[31:2]] = w;
      bus.sram_rdata <= w;
    end
  end

  // Reference model state
  int          waits     = 0;
  bit          last_data = 1'b0;
  bit          pend_i = 1'b0, pend_d = 1'b0, pend_d_rd = 1'b0;
  logic [31:0] pend_i_val = '0, pend_d_val = '0;
  logic [31:0] held_i = '0, held_d = '0;

  always @(negedge clk) begin : model
    bit          ig, dg;
    logic [31:0] ea, w;
    if (reset) begin
      chk("rst_inst_gnt",  32'(bus.inst_gnt),  32'h0);
      chk("rst_data_gnt",  32'(bus.data_gnt),  32'h0);
      chk("rst_sram_en",   32'(bus.sram_en),   32'h0);
      chk("rst_sram_we",   32'(bus.sram_we),   32'h0);
      chk("rst_inst_resp", 32'(bus.inst_resp), 32'h0);
      chk("rst_data_resp", 32'(bus.data_resp), 32'h0);
      waits = 0; last_data = 1'b0;
      pend_i = 1'b0; pend_d = 1'b0; pend_d_rd = 1'b0;
      held_i = '0; held_d = '0;
    end else begin
      if (pend_i) held_i = pend_i_val;
      if (pend_d && pend_d_rd) held_d = pend_d_val;
      chk("inst_resp",  32'(bus.inst_resp), 32'(pend_i));
      chk("data_resp",  32'(bus.data_resp), 32'(pend_d));
      chk("inst_rdata", bus.inst_rdata, held_i);
      chk("data_rdata", bus.data_rdata, held_d);
`ifdef SRAM_ARB_RR_EN
      dg = bus.data_req && !(bus.inst_req && last_data);
`else
      dg = bus.data_req && !(bus.inst_req && waits == int'(MAX_WAIT));
`endif
      ig = bus.inst_req && !dg;
      ea = dg ? (bus.data_addr & ~32'h3) : ig ? (bus.inst_addr & ~32'h3) : 32'h0;
      chk("inst_gnt",   32'(bus.inst_gnt), 32'(ig));
      chk("data_gnt",   32'(bus.data_gnt), 32'(dg));
      chk("sram_en",    32'(bus.sram_en), 32'(ig || dg));
      chk("sram_we",    32'(bus.sram_we), (dg && bus.data_wr) ? 32'(bus.data_wstrb) : 32'h0);
      chk("sram_addr",  bus.sram_addr, ea);
      chk("sram_wdata", bus.sram_wdata, dg ? bus.data_wdata : 32'h0);
      pend_i = ig;
      pend_d = dg;
      if (ig) pend_i_val = ref_rd(bus.inst_addr[31:2]);
      if (dg) begin
        if (bus.data_wr) begin
          w = merge(ref_rd(bus.data_addr[31:2]), bus.data_wdata, bus.data_wstrb);
          ref_mem[bus.data_addr[31:2]] = w;
          pend_d_rd = 1'b0;
        end else begin
          pend_d_val = ref_rd(bus.data_addr[31:2]);
          pend_d_rd  = 1'b1;
        end
      end
      if (!bus.inst_req || ig) waits = 0;
      else if (dg && waits < int'(MAX_WAIT)) waits++;
      if (dg) last_data = 1'b1;
      else if (ig) last_data = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113;

    reset = 1'b1;
    bus.inst_req = 1'b0; bus.inst_addr = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = '0;
    bus.data_addr = '0;  bus.data_wdata = '0;

    sram_mem[30'h0700_0004] = 32'hdead_beef; ref_mem[30'h0700_0004] = 32'hdead_beef;
    sram_mem[30'h0000_0040] = 32'hffff_ffff; ref_mem[30'h0000_0040] = 32'hffff_ffff;
    for (int i = 0; i < 3; i++) begin
      sram_mem[30'h0700_0000 + 30'(i)] = words[i];
      ref_mem[30'h0700_0000 + 30'(i)]  = words[i];
    end

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("lit_rst_inst_rdata", bus.inst_rdata, 32'h0);
    chk("lit_rst_data_rdata", bus.data_rdata, 32'h0);
    tick();
    reset = 1'b0;

    // Single load
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1c00_0010;
    @(negedge clk);
    chk("lit_load_gnt",  32'(bus.data_gnt), 32'h1);
    chk("lit_load_addr", bus.sram_addr, 32'h1c00_0010);
    tick();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("lit_load_resp",  32'(bus.data_resp), 32'h1);
    chk("lit_load_rdata", bus.data_rdata, 32'hdead_beef);
    tick();
    @(negedge clk);
    chk("lit_load_resp_end", 32'(bus.data_resp), 32'h0);
    chk("lit_load_held",     bus.data_rdata, 32'hdead_beef);

    // Partial store then load of the same word
    tick();
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
    bus.data_addr = 32'h0000_0100; bus.data_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("lit_store_we", 32'(bus.sram_we), 32'h3);
    tick();
    bus.data_wr = 1'b0; bus.data_wstrb = 4'b0000;
    @(negedge clk);
    chk("lit_store_resp",      32'(bus.data_resp), 32'h1);
    chk("lit_store_keeps_rd",  bus.data_rdata, 32'hdead_beef);
    chk("lit_store_inst_idle", 32'(bus.inst_resp), 32'h0);
    tick();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("lit_merged_rdata", bus.data_rdata, 32'hffff_5678);
    chk("lit_inst_untouched", bus.inst_rdata, 32'h0);

    // Back-to-back instruction fetches
    tick();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0000;
    @(negedge clk);
    chk("lit_fetch0_gnt", 32'(bus.inst_gnt), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) bus.inst_addr = 32'h1c00_0000 + 32'(4 * i);
      else       bus.inst_req = 1'b0;
      @(negedge clk);
      chk("lit_fetch_resp",  32'(bus.inst_resp), 32'h1);
      chk("lit_fetch_rdata", bus.inst_rdata, words[i-1]);
    end
    tick();
    @(negedge clk);
    chk("lit_fetch_held", bus.inst_rdata, 32'h0020_0113);

    // Build up some contention history, then reset right after a data grant
    tick();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0000;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h0000_0100;
    @(negedge clk);
    chk("lit_pre_rst_gnt", 32'(bus.data_gnt), 32'h1);
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_rst_cycle_resp", 32'(bus.data_resp), 32'h0);
    tick();
    reset = 1'b0;

    // Sustained contention from a clean state
    for (int k = 0; k < 10; k++) begin
      logic [1:0] exp_gnt;
      if (k > 0) tick();
      @(negedge clk);
      if (k == 0) begin
        chk("lit_post_rst_resp",  32'(bus.data_resp), 32'h0);
        chk("lit_post_rst_rdata", bus.data_rdata, 32'h0);
      end
`ifdef SRAM_ARB_RR_EN
      exp_gnt = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_gnt = (k % 5 == 4) ? 2'b01 : 2'b10;
`endif
      chk("lit_contention_gnt", 32'({bus.data_gnt, bus.inst_gnt}), 32'(exp_gnt));
    end

    tick();
    bus.inst_req = 1'b0; bus.data_req = 1'b0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM (1-cycle read latency) between the instruction-fetch requester and the data (load/store) requester of the multi-cycle CPU core.
- Grants at most one access per cycle. Data requests have fixed priority; a starvation guard forces an instruction grant after a bounded wait.
- Returns per-requester response pulses, and holds read data stable until the next read response for that port.
- Sits between the core's IF/MEM stages and the unified memory macro.

Parameters:
- ADDR_W, 32, byte address width.
- MAX_WAIT, 4, consecutive cycles an instruction request may lose to data before it is forced through (range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- inst_req  input  1  instruction read request; held until inst_gnt.
- inst_addr  input  ADDR_W  instruction word address (bits [1:0] ignored).
- inst_gnt  output  1  request accepted this cycle.
- inst_resp  output  1  read data available, one cycle after inst_gnt.
- inst_rdata  output  32  instruction read data, held.
- data_req  input  1  data request; held until data_gnt.
- data_wr  input  1  1 = store, 0 = load.
- data_wstrb  input  4  byte write enables (store only).
- data_addr  input  ADDR_W  data address.
- data_wdata  input  32  store data.
- data_gnt  output  1  request accepted this cycle.
- data_resp  output  1  completion pulse, one cycle after data_gnt (loads and stores).
- data_rdata  output  32  load data, held; unchanged by stores.
- sram_en  output  1  SRAM access enable.
- sram_we  output  4  SRAM byte write enables.
- sram_addr  output  ADDR_W  SRAM address, {addr[ADDR_W-1:2], 2'b00}.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM read data, valid the cycle after sram_en.

Behaviour:
- Grant logic is combinational on the current requests and the registered state.
  - Data wins if data_req && !(inst_req && starve_cnt == MAX_WAIT).
  - Otherwise inst wins if inst_req.
- starve_cnt is 4 bits and saturates at MAX_WAIT.
  - Increments when inst_req is high and data is granted.
  - Clears when inst is granted, or when inst_req is low.
- SRAM drive in the grant cycle:
  - sram_en = inst_gnt | data_gnt.
  - sram_we = data_gnt && data_wr ? data_wstrb : 4'b0.
  - sram_addr and sram_wdata are muxed from the winner.
  - With no grant, sram_en = 0, sram_we = 0, and address/wdata are don't-care (drive 0).
- Owner tag register: {valid, is_data, is_read}, captured from the grant cycle.
- Response cycle (cycle after the grant):
  - Inst owner: inst_resp = 1 and inst_rdata <= sram_rdata.
  - Data owner: data_resp = 1; data_rdata <= sram_rdata only if is_read.
  - Each response lasts exactly 1 cycle.
- Throughput: back-to-back grants every cycle are allowed. A new grant may coincide with the previous response cycle.
- Requests deasserted before grant are dropped with no response. Requests held across a grant cycle are treated as new requests.
- Write-then-read to the same address in consecutive cycles returns the new data (SRAM is write-first).
- Reset:
  - All outputs go to 0, inst_rdata/data_rdata = 32'h0, starve_cnt = 0, owner tag invalid.
  - A grant issued in the cycle reset asserts yields no response after reset.
- inst_req and data_req both low: idle with no state change except starve_cnt clearing.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: fixed priority and starve_cnt are replaced by 1-bit round-robin.
  - last_owner (reset = inst, so data wins the first tie).
  - On a tie the port not granted last wins.
  - last_owner updates on every grant.
  - MAX_WAIT is unused.
- Undefined: fixed data priority with the starvation guard, as above.

Test Plan:
- Single load: data_req=1, data_wr=0, data_addr=0x1c000010, memory word 0xdeadbeef → data_gnt in cycle 0, sram_addr=0x1c000010, data_resp in cycle 1, data_rdata=0xdeadbeef held afterwards.
- Store then load: store wstrb=4'b0011, wdata=0x12345678 to 0x100 (previously 0xffffffff), then load 0x100 → sram_we=4'b0011, data_rdata=0xffff5678, inst port untouched.
- Contention (default build, MAX_WAIT=4): inst_req and data_req held high continuously → grant pattern D,D,D,D,I repeating; inst_resp once every 5 cycles.
- Contention with SRAM_ARB_RR_EN: same stimulus → grants alternate D,I,D,I starting with D.
- Back-to-back inst fetches at 0x1c000000, 0x1c000004, 0x1c000008 with no data traffic → grant every cycle, three inst_resp pulses in consecutive cycles with matching data.
- Reset mid-access: assert reset in the cycle of a data_gnt for a load → no data_resp afterwards, data_rdata=0, starve_cnt=0, and the next request is granted normally.
